// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: opcode encodings, flag bit positions
// and the opcode legality check.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam int unsigned NumFlags = 4;
  localparam int unsigned FLAG_N   = 3;
  localparam int unsigned FLAG_Z   = 2;
  localparam int unsigned FLAG_C   = 1;
  localparam int unsigned FLAG_V   = 0;

  function automatic logic is_legal_op(input logic [2:0] op);
    logic legal;
    case (op)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT: legal = 1'b1;
      default:                                    legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO for the ALU issue stage; head is the oldest entry,
// visible combinationally. Depth must be a power of two.
module alu_cmd_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         head_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_en, pop_en;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

  // Guard locally so a misbehaving caller cannot corrupt the pointers.
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_en) wptr_d = wptr_q + PtrW'(1);
    if (pop_en)  rptr_d = rptr_q + PtrW'(1);
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: occupancy gates every read of stale entries.
  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage around the combinational ALU: buffers requests, feeds the ALU from the
// FIFO head and captures result/flags into a one-entry output register.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_op,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [2:0]               alu_control,
  input  logic [WIDTH-1:0]         alu_result,
  input  logic                     alu_overflow,
  input  logic                     alu_carry,
  input  logic                     alu_zero,
  input  logic                     alu_negative,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result,
  output logic [3:0]               out_flags,
  output logic                     out_err,
  output logic [3:0]               sticky_flags,
  input  logic                     clr_sticky,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned CmdW = 3 + 2 * WIDTH;

  logic [CmdW-1:0]  cmd_wdata, cmd_head;
  logic             cmd_full, cmd_empty;
  logic             push, pop;
  logic [2:0]       head_op;
  logic [WIDTH-1:0] head_a, head_b;
  logic             head_legal;
  logic [3:0]       alu_flags;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;
  logic [3:0]       out_flags_q, out_flags_d;
  logic             out_err_q, out_err_d;
  logic [3:0]       sticky_q, sticky_d;

  assign in_ready  = !cmd_full;
  assign push      = in_valid && in_ready;
  // The output register is free when empty or being drained this cycle.
  assign pop       = !cmd_empty && (!out_valid_q || out_ready);
  assign cmd_wdata = {in_op, in_a, in_b};

  alu_cmd_fifo #(
    .Width (CmdW),
    .Depth (DEPTH)
  ) u_cmd_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .wdata_i (cmd_wdata),
    .pop_i   (pop),
    .head_o  (cmd_head),
    .count_o (count),
    .full_o  (cmd_full),
    .empty_o (cmd_empty)
  );

  assign head_op    = cmd_head[CmdW-1 -: 3];
  assign head_a     = cmd_head[2*WIDTH-1 -: WIDTH];
  assign head_b     = cmd_head[WIDTH-1:0];
  assign head_legal = is_legal_op(head_op);

  always_comb begin
    alu_a       = '0;
    alu_b       = '0;
    alu_control = ALU_ADD;
    if (!cmd_empty) begin
      alu_a       = head_a;
      alu_b       = head_b;
      alu_control = head_op;
    end
  end

  always_comb begin
    alu_flags         = '0;
    alu_flags[FLAG_N] = alu_negative;
    alu_flags[FLAG_Z] = alu_zero;
    alu_flags[FLAG_C] = alu_carry;
    alu_flags[FLAG_V] = alu_overflow;
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_flags_d  = out_flags_q;
    out_err_d    = out_err_q;
    sticky_d     = clr_sticky ? 4'b0000 : sticky_q;
    if (pop) begin
      out_valid_d = 1'b1;
      if (head_legal) begin
        out_result_d = alu_result;
        out_flags_d  = alu_flags;
        out_err_d    = 1'b0;
        sticky_d     = sticky_d | alu_flags;
      end else begin
        out_result_d = '0;
        out_flags_d  = 4'b0000;
        out_err_d    = 1'b1;
      end
    end else if (out_ready) begin
      // Consumed with nothing behind it; payload fields keep their last values.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= 4'b0000;
      out_err_q    <= 1'b0;
      sticky_q     <= 4'b0000;
    end else begin
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_flags_q  <= out_flags_d;
      out_err_q    <= out_err_d;
      sticky_q     <= sticky_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_result   = out_result_q;
  assign out_flags    = out_flags_q;
  assign out_err      = out_err_q;
  assign sticky_flags = sticky_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage with a behavioural ALU closing the loop.
module tb_alu_issue_stage;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;

  logic             clk, rst_n;
  logic             in_valid, in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a, in_b;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic [2:0]       alu_control;
  logic             alu_overflow, alu_carry, alu_zero, alu_negative;
  logic             out_valid, out_ready, out_err, clr_sticky;
  logic [WIDTH-1:0] out_result;
  logic [3:0]       out_flags, sticky_flags;
  logic [2:0]       count;

  typedef struct packed {
    logic        err;
    logic [3:0]  flags;
    logic [31:0] res;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  alu_issue_stage #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_a         (in_a),
    .in_b         (in_b),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_control  (alu_control),
    .alu_result   (alu_result),
    .alu_overflow (alu_overflow),
    .alu_carry    (alu_carry),
    .alu_zero     (alu_zero),
    .alu_negative (alu_negative),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .out_err      (out_err),
    .sticky_flags (sticky_flags),
    .clr_sticky   (clr_sticky),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Returns {N,Z,C,V,result}; sub carry is a borrow. Illegal codes give junk on purpose.
  function automatic logic [35:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic        c, v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'b000: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0];
        c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'b001: begin
        r = a - b;
        c = (a < b);
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      3'b010:  r = a & b;
      3'b011:  r = a | b;
      3'b101:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: begin
        r = 32'hDEAD_BEEF;
        c = 1'b1;
        v = 1'b1;
      end
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  function automatic exp_t expect_of(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    exp_t        e;
    logic [35:0] t;
    t = ref_alu(op, a, b);
    if (op inside {3'b000, 3'b001, 3'b010, 3'b011, 3'b101}) begin
      e.err   = 1'b0;
      e.flags = t[35:32];
      e.res   = t[31:0];
    end else begin
      e.err   = 1'b1;
      e.flags = 4'b0000;
      e.res   = 32'd0;
    end
    return e;
  endfunction

  logic [35:0] alu_resp;
  always_comb alu_resp = ref_alu(alu_control, alu_a, alu_b);
  assign alu_result   = alu_resp[31:0];
  assign alu_overflow = alu_resp[32];
  assign alu_carry    = alu_resp[33];
  assign alu_zero     = alu_resp[34];
  assign alu_negative = alu_resp[35];

  // Inputs change only #1 after posedge, so negedge values are the ones the next edge sees.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("spurious_out", out_valid, 1'b0);
        end else begin
          mon_e = sb.pop_front();
          check_eq("sb_result", out_result, mon_e.res);
          check_eq("sb_flags", out_flags, mon_e.flags);
          check_eq("sb_err", out_err, mon_e.err);
        end
      end
      if (in_valid && in_ready) sb.push_back(expect_of(in_op, in_a, in_b));
    end
  end

  always @(negedge rst_n) sb.delete();

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) check_eq("send_timeout", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
  endtask

  logic [2:0] ops [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101};
  int         accepted;

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_op      = 3'b000;
    in_a       = '0;
    in_b       = '0;
    out_ready  = 1'b0;
    clr_sticky = 1'b0;
    tick();
    tick();
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_count", count, 3'd0);
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_out_result", out_result, 32'd0);
    check_eq("rst_flags_err", {out_err, out_flags}, 5'b0);
    check_eq("rst_sticky", sticky_flags, 4'b0000);
    check_eq("rst_alu_ab", alu_a | alu_b, 32'd0);
    check_eq("rst_alu_ctl", alu_control, 3'b000);
    #2 rst_n = 1'b1;
    tick();

    // First request: latency of two edges
    out_ready = 1'b1;
    send(3'b000, 32'h10, 32'h20);
    check_eq("lat_k_valid", out_valid, 1'b0);
    check_eq("lat_k_count", count, 3'd1);
    check_eq("lat_k_alu_a", alu_a, 32'h10);
    check_eq("lat_k_alu_b", alu_b, 32'h20);
    tick();
    check_eq("lat_k1_valid", out_valid, 1'b1);
    check_eq("lat_k1_result", out_result, 32'h30);
    check_eq("lat_k1_flags", out_flags, 4'b0000);
    check_eq("lat_k1_err", out_err, 1'b0);
    tick();
    check_eq("drain_valid", out_valid, 1'b0);
    check_eq("drain_hold_result", out_result, 32'h30);

    // Backpressure: six offered, five fit (FIFO plus output register)
    out_ready = 1'b0;
    accepted  = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_op    = ops[i % 5];
      in_a     = (i % 2 == 0) ? $urandom : $urandom_range(0, 255);
      in_b     = $urandom;
      if (!in_ready) break;
      tick();
      accepted++;
    end
    in_valid = 1'b0;
    check_eq("bp_accepted", accepted, 5);
    check_eq("bp_in_ready", in_ready, 1'b0);
    check_eq("bp_count", count, 3'd4);
    check_eq("bp_out_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_eq("tp_valid", out_valid, 1'b1);
      check_eq("tp_count", count, 4 - i);
    end
    tick();
    check_eq("tp_end_valid", out_valid, 1'b0);

    // Flag extraction and sticky accumulation
    pulse_clr();
    check_eq("clr_sticky0", sticky_flags, 4'b0000);
    send(3'b000, 32'h7FFF_FFFF, 32'h1);
    tick();
    check_eq("ovf_result", out_result, 32'h8000_0000);
    check_eq("ovf_flags", out_flags, 4'b1001);
    check_eq("ovf_sticky", sticky_flags, 4'b1001);
    send(3'b000, 32'hFFFF_FFFF, 32'h1);
    tick();
    check_eq("carry_result", out_result, 32'h0);
    check_eq("carry_flags", out_flags, 4'b0110);
    check_eq("sticky_all", sticky_flags, 4'b1111);
    tick();
    pulse_clr();
    check_eq("sticky_cleared", sticky_flags, 4'b0000);

    // Illegal opcode
    send(3'b111, 32'h5, 32'h6);
    tick();
    check_eq("ill_valid", out_valid, 1'b1);
    check_eq("ill_result", out_result, 32'h0);
    check_eq("ill_flags", out_flags, 4'b0000);
    check_eq("ill_err", out_err, 1'b1);
    check_eq("ill_sticky", sticky_flags, 4'b0000);

    // Clear coinciding with a capture
    send(3'b000, 32'h7FFF_FFFF, 32'h1);
    tick();
    check_eq("pre_clr_sticky", sticky_flags, 4'b1001);
    send(3'b001, 32'h10, 32'h10);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    check_eq("clrcap_result", out_result, 32'h0);
    check_eq("clrcap_flags", out_flags, 4'b0100);
    check_eq("clrcap_sticky", sticky_flags, 4'b0100);
    tick();

    // Asynchronous reset with work in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(ops[i], $urandom, $urandom);
    check_eq("pre_rst_count", count, 3'd2);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", out_valid, 1'b0);
    check_eq("arst_count", count, 3'd0);
    check_eq("arst_in_ready", in_ready, 1'b1);
    check_eq("arst_sticky", sticky_flags, 4'b0000);
    check_eq("arst_alu_a", alu_a, 32'd0);
    tick();
    tick();
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("post_rst_idle", out_valid, 1'b0);
    end
    send(3'b000, 32'h3, 32'h4);
    tick();
    check_eq("post_rst_valid", out_valid, 1'b1);
    check_eq("post_rst_result", out_result, 32'h7);
    tick();
    tick();
    check_eq("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
